// File: rtl/rate_tick_gen.sv
// rtl/rate_tick_gen.sv - clock-enable tick generator with free-run rates and debounced single-step
module rate_tick_gen #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    input  logic       step_mode,
    input  logic       step_btn,
    output logic       tick,
    output logic       heartbeat
);

    localparam int CW = (4 * CLK_HZ > 1) ? $clog2(4 * CLK_HZ) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STEP_ARMED = 2'd1,
        STEP_HELD  = 2'd2
    } state_t;

    state_t                 state;
    logic [1:0]             rate_reg;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   db_level;
    logic                   db_prev;
    logic [DW-1:0]          stable_cnt;
    logic                   press;
    logic                   release_ev;

    // Terminal count for a rate selection: period minus one.
    function automatic logic [CW-1:0] reload(input logic [1:0] r);
        logic [CW-1:0] v;
        case (r)
            2'b00:   v = '0;
            2'b01:   v = CW'(CLK_HZ - 1);
            2'b10:   v = CW'(2 * CLK_HZ - 1);
            default: v = CW'(4 * CLK_HZ - 1);
        endcase
        return v;
    endfunction

    // Button path: synchroniser, then a level that only moves after a long stable run.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync       <= '1;
            db_level   <= 1'b1;
            db_prev    <= 1'b1;
            stable_cnt <= '0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], step_btn};
            db_prev <= db_level;
            if (sync[SYNC_STAGES-1] == db_level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_LAST) begin
                stable_cnt <= '0;
                db_level   <= sync[SYNC_STAGES-1];
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    assign press      = db_prev & ~db_level;
    assign release_ev = ~db_prev & db_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            rate_reg  <= rate_sel;
            cnt       <= reload(rate_sel);
            tick      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (state)
                RUN: begin
                    if (step_mode) begin
                        state <= STEP_ARMED;
                    end else if (rate_sel != rate_reg) begin
                        rate_reg <= rate_sel;
                        cnt      <= reload(rate_sel);
                    end else if (enable) begin
                        if (cnt == '0) begin
                            tick      <= 1'b1;
                            heartbeat <= ~heartbeat;
                            cnt       <= reload(rate_reg);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                STEP_ARMED: begin
                    if (!step_mode) begin
                        state    <= RUN;
                        rate_reg <= rate_sel;
                        cnt      <= reload(rate_sel);
                    end else if (press) begin
                        state <= STEP_HELD;
                        if (enable) begin
                            tick      <= 1'b1;
                            heartbeat <= ~heartbeat;
                        end
                    end
                end
                STEP_HELD: begin
                    if (!step_mode) begin
                        state    <= RUN;
                        rate_reg <= rate_sel;
                        cnt      <= reload(rate_sel);
                    end else if (release_ev) begin
                        state <= STEP_ARMED;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rate_tick_gen.sv
// tb/tb_rate_tick_gen.sv - self-checking bench for rate_tick_gen
module tb_rate_tick_gen;

    localparam int CLK_HZ          = 4;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] rate_sel;
    logic       step_mode;
    logic       step_btn;
    logic       tick;
    logic       heartbeat;

    int checks = 0;
    int errors = 0;

    // Reference: enabled cycles elapsed since the last tick or reload; a tick every P of them.
    int m_elapsed;
    int m_rate;
    bit m_tick;
    bit m_hb;

    always #5 clk = ~clk;

    rate_tick_gen #(
        .CLK_HZ(CLK_HZ),
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .rate_sel(rate_sel),
        .step_mode(step_mode),
        .step_btn(step_btn),
        .tick(tick),
        .heartbeat(heartbeat)
    );

    function automatic int period(input int r);
        case (r)
            0:       return 1;
            1:       return CLK_HZ;
            2:       return 2 * CLK_HZ;
            default: return 4 * CLK_HZ;
        endcase
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_elapsed = 0;
            m_rate    = int'(rate_sel);
            m_tick    = 1'b0;
            m_hb      = 1'b0;
        end else if (int'(rate_sel) != m_rate) begin
            m_rate    = int'(rate_sel);
            m_elapsed = 0;
            m_tick    = 1'b0;
        end else if (!enable) begin
            m_tick = 1'b0;
        end else begin
            m_elapsed++;
            m_tick = (m_elapsed == period(m_rate));
            if (m_tick) begin
                m_elapsed = 0;
                m_hb      = ~m_hb;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] r);
        reset    = 1'b1;
        rate_sel = r;
        cycle();
        reset = 1'b0;
    endtask

    // Holds the button low for hold cycles, releases it for tail cycles, and reports ticks seen.
    task automatic press_and_count(input int hold, input int tail, output int ticks,
                                   output int first, output bit dbl);
        bit prev;
        ticks = 0;
        first = -1;
        dbl   = 1'b0;
        prev  = tick;
        step_btn = 1'b0;
        for (int i = 1; i <= hold + tail; i++) begin
            if (i == hold + 1) step_btn = 1'b1;
            cycle();
            if (tick) begin
                ticks++;
                if (first < 0) first = i;
                if (prev) dbl = 1'b1;
            end
            prev = tick;
        end
    endtask

    task automatic test_reset();
        enable = 1'b1; step_mode = 1'b0; step_btn = 1'b1;
        reset = 1'b1; rate_sel = 2'b01;
        cycle();
        cycle();
        checks++;
        if (tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick got %b want 0", tick);
        end
        checks++;
        if (heartbeat !== 1'b0) begin
            errors++; $display("FAIL reset_heartbeat got %b want 0", heartbeat);
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        enable = 1'b1;
        do_reset(2'b01);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            checks++;
            if (tick !== ((k % 4) == 0)) begin
                errors++; $display("FAIL free_run_tick cycle %0d got %b want %b", k, tick, (k % 4) == 0);
            end
            checks++;
            if (heartbeat !== logic'((k / 4) % 2)) begin
                errors++; $display("FAIL free_run_hb cycle %0d got %b want %0d", k, heartbeat, (k / 4) % 2);
            end
        end
    endtask

    task automatic test_rate_switch();
        enable = 1'b1;
        do_reset(2'b00);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checks++;
            if (tick !== 1'b1) begin
                errors++; $display("FAIL rate00_tick cycle %0d got %b want 1", k, tick);
            end
        end
        rate_sel = 2'b11;
        cycle();
        checks++;
        if (tick !== 1'b0) begin
            errors++; $display("FAIL reload_cycle_tick got %b want 0", tick);
        end
        for (int j = 1; j <= 16; j++) begin
            cycle();
            checks++;
            if (tick !== (j == 16)) begin
                errors++; $display("FAIL rate11_tick offset %0d got %b want %b", j, tick, j == 16);
            end
        end
    endtask

    task automatic test_enable_gating();
        enable = 1'b1;
        do_reset(2'b01);
        cycle();
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            checks++;
            if (tick !== 1'b0) begin
                errors++; $display("FAIL gated_tick step %0d got %b want 0", k, tick);
            end
        end
        enable = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            cycle();
            checks++;
            if (tick !== (j == 3)) begin
                errors++; $display("FAIL resume_tick offset %0d got %b want %b", j, tick, j == 3);
            end
        end
    endtask

    task automatic test_random();
        enable = 1'b1;
        step_mode = 1'b0;
        do_reset(2'($urandom_range(0, 3)));
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) rate_sel = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 9) < 8);
            cycle();
            checks++;
            if (tick !== m_tick) begin
                errors++; $display("FAIL random_tick iter %0d got %b want %b", i, tick, m_tick);
            end
            checks++;
            if (heartbeat !== m_hb) begin
                errors++; $display("FAIL random_hb iter %0d got %b want %b", i, heartbeat, m_hb);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_step();
        int ticks, first;
        bit dbl;
        enable = 1'b1; step_mode = 1'b0; step_btn = 1'b1;
        do_reset(2'b01);
        step_mode = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        for (int p = 0; p < 2; p++) begin
            press_and_count(10, 15, ticks, first, dbl);
            checks++;
            if (ticks != 1) begin
                errors++; $display("FAIL step_ticks press %0d got %0d want 1", p, ticks);
            end
            checks++;
            if (first < SYNC_STAGES + DEBOUNCE_CYCLES || first > SYNC_STAGES + DEBOUNCE_CYCLES + 2) begin
                errors++; $display("FAIL step_latency press %0d got %0d want %0d+-1", p, first,
                                   SYNC_STAGES + DEBOUNCE_CYCLES + 1);
            end
            checks++;
            if (dbl) begin
                errors++; $display("FAIL step_double press %0d got consecutive ticks want none", p);
            end
        end
        enable = 1'b0;
        press_and_count(10, 15, ticks, first, dbl);
        checks++;
        if (ticks != 0) begin
            errors++; $display("FAIL step_disabled_ticks got %0d want 0", ticks);
        end
        enable = 1'b1;
    endtask

    task automatic test_bounce();
        int ticks, first, glitch_ticks;
        bit dbl;
        glitch_ticks = 0;
        for (int g = 0; g < 3; g++) begin
            step_btn = 1'b0;
            for (int k = 0; k < 2; k++) begin
                cycle();
                if (tick) glitch_ticks++;
            end
            step_btn = 1'b1;
            for (int k = 0; k < 3; k++) begin
                cycle();
                if (tick) glitch_ticks++;
            end
        end
        checks++;
        if (glitch_ticks != 0) begin
            errors++; $display("FAIL bounce_glitch_ticks got %0d want 0", glitch_ticks);
        end
        press_and_count(12, 15, ticks, first, dbl);
        checks++;
        if (ticks != 1) begin
            errors++; $display("FAIL bounce_stable_ticks got %0d want 1", ticks);
        end
        checks++;
        if (first < SYNC_STAGES + DEBOUNCE_CYCLES || first > SYNC_STAGES + DEBOUNCE_CYCLES + 2) begin
            errors++; $display("FAIL bounce_latency got %0d want %0d+-1", first, SYNC_STAGES + DEBOUNCE_CYCLES + 1);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1; step_mode = 1'b1; step_btn = 1'b1;
        do_reset(2'b01);
        for (int k = 0; k < 3; k++) cycle();
        step_btn = 1'b0;
        for (int k = 0; k < 9; k++) cycle();
        checks++;
        if (heartbeat !== 1'b1) begin
            errors++; $display("FAIL held_heartbeat got %b want 1", heartbeat);
        end
        reset = 1'b1;
        step_mode = 1'b0;
        cycle();
        reset = 1'b0;
        step_btn = 1'b1;
        checks++;
        if (heartbeat !== 1'b0) begin
            errors++; $display("FAIL midreset_heartbeat got %b want 0", heartbeat);
        end
        checks++;
        if (tick !== 1'b0) begin
            errors++; $display("FAIL midreset_tick got %b want 0", tick);
        end
        for (int j = 1; j <= 4; j++) begin
            cycle();
            checks++;
            if (tick !== (j == 4)) begin
                errors++; $display("FAIL post_reset_tick offset %0d got %b want %b", j, tick, j == 4);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rate_sel = 2'b00; step_mode = 1'b0; step_btn = 1'b1;
        test_reset();
        test_free_run();
        test_rate_switch();
        test_enable_gating();
        test_random();
        test_step();
        test_bounce();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
